// File: rtl/core_ctrl_multi_pkg.sv
// Shared definitions for the per-core clock-gate / reset sequencer.
package core_ctrl_multi_pkg;

    // Channel sequencing states.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Counter width that can hold the larger of the two delay terminal values.
    function automatic int cnt_w(input int rst_delay, input int stop_delay);
        int max_delay;
        max_delay = (rst_delay > stop_delay) ? rst_delay : stop_delay;
        return $clog2(max_delay + 1);
    endfunction

endpackage

// File: rtl/core_ctrl_multi_chan.sv
// One core channel: enable synchroniser, power sequencing FSM with delay
// counter, glitch-free clock gate and core reset synchroniser.
module core_ctrl_multi_chan
    import core_ctrl_multi_pkg::*;
#(
    parameter int RST_DELAY  = 8,
    parameter int STOP_DELAY = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic core_en_i,
    output logic clk_core_o,
    output logic reset_core_n_o,
    output logic core_running_o,
    output logic core_busy_o
);

    localparam int               CNT_W     = cnt_w(RST_DELAY, STOP_DELAY);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_DELAY - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             en_p0;
    logic             en_s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clk_en_q;
    logic             rst_n_int_q;
    logic             rst_p0;
    logic             rst_p1;

    // Two-flop synchroniser for the asynchronous enable request.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            en_p0 <= 1'b0;
            en_s  <= 1'b0;
        end else begin
            en_p0 <= core_en_i;
            en_s  <= en_p0;
        end
    end

    // Next-state and counter logic; counters stop at their terminal value
    // because the state always leaves on that cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (en_s) state_d = ST_START;
            end
            ST_START: begin
                if (!en_s) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!en_s) state_d = ST_STOP;
            end
            ST_STOP: begin
                // The drain window always completes before the enable is looked at.
                if (cnt_q == STOP_LAST) begin
                    cnt_d   = '0;
                    state_d = en_s ? ST_START : ST_OFF;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered clock-enable / internal reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            clk_en_q    <= 1'b0;
            rst_n_int_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clk_en_q    <= (state_d != ST_OFF);
            rst_n_int_q <= (state_d == ST_RUN);
        end
    end

`ifdef XILINX_FPGA
    assign clk_core_o = clk_i;
`else
    logic gate_en_q;

    // Enable captured while clk_i is low so the AND gate cannot glitch.
    always_ff @(negedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) gate_en_q <= 1'b0;
        else            gate_en_q <= clk_en_q;
    end

    assign clk_core_o = clk_i & gate_en_q;
`endif

    // Core reset: asserts asynchronously, releases after two core-clock edges.
    always_ff @(posedge clk_core_o or negedge rst_n_int_q) begin
        if (!rst_n_int_q) begin
            rst_p0 <= 1'b0;
            rst_p1 <= 1'b0;
        end else begin
            rst_p0 <= 1'b1;
            rst_p1 <= rst_p0;
        end
    end

    assign reset_core_n_o = rst_p1;
    assign core_running_o = (state_q == ST_RUN);
    assign core_busy_o    = (state_q == ST_START) || (state_q == ST_STOP);

endmodule

// File: rtl/core_ctrl_multi.sv
// Per-core clock-gate and reset sequencer for a tile of NUM_CORES cores.
// Channels are independent; only clk_i and reset_n_i are shared.
module core_ctrl_multi
    import core_ctrl_multi_pkg::*;
#(
    parameter int NUM_CORES  = 1,
    parameter int RST_DELAY  = 8,
    parameter int STOP_DELAY = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [NUM_CORES-1:0] core_en_i,
    output logic [NUM_CORES-1:0] clk_core_o,
    output logic [NUM_CORES-1:0] reset_core_n_o,
    output logic [NUM_CORES-1:0] core_running_o,
    output logic [NUM_CORES-1:0] core_busy_o
);

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_chan
        core_ctrl_multi_chan #(
            .RST_DELAY  (RST_DELAY),
            .STOP_DELAY (STOP_DELAY)
        ) u_chan (
            .clk_i          (clk_i),
            .reset_n_i      (reset_n_i),
            .core_en_i      (core_en_i[g]),
            .clk_core_o     (clk_core_o[g]),
            .reset_core_n_o (reset_core_n_o[g]),
            .core_running_o (core_running_o[g]),
            .core_busy_o    (core_busy_o[g])
        );
    end

endmodule
